// File: rtl/branch_pred_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pred_unit
//  Description : Direct-mapped 2-bit-counter branch predictor with BTB,
//                training from execute and registered mispredict/redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_pred_unit #(
    parameter int PC_W  = 16,
    parameter int IDX_W = 6,
    parameter int CNT_W = 2,
    parameter int TAG_W = PC_W - IDX_W
) (
    input  logic            clk,
    input  logic            rst_n,
    // fetch lookup
    input  logic            f_valid,
    input  logic [PC_W-1:0] f_pc,
    input  logic            f_stall,
    output logic            p_valid,
    output logic            p_taken,
    output logic [PC_W-1:0] p_target,
    // execute resolution
    input  logic            u_valid,
    input  logic [PC_W-1:0] u_pc,
    input  logic            u_taken,
    input  logic [PC_W-1:0] u_target,
    input  logic            u_pred_taken,
    input  logic [PC_W-1:0] u_pred_target,
    output logic            mispredict,
    output logic [PC_W-1:0] redirect_pc
);

    localparam int             DEPTH        = 1 << IDX_W;
    localparam logic [CNT_W-1:0] C_CNT_WEAK_NT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] C_CNT_WEAK_T  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] C_CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_MIN     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] C_CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0]  C_PC_ONE      = {{(PC_W-1){1'b0}}, 1'b1};

    // prediction table
    logic             r_valid [DEPTH];
    logic [TAG_W-1:0] r_tag   [DEPTH];
    logic [PC_W-1:0]  r_btb   [DEPTH];
    logic [CNT_W-1:0] r_cnt   [DEPTH];

    // output registers
    logic             r_p_valid;
    logic             r_p_taken;
    logic [PC_W-1:0]  r_p_target;
    logic             r_mispredict;
    logic [PC_W-1:0]  r_redirect_pc;

    // lookup path
    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic             w_f_taken;
    logic [PC_W-1:0]  w_f_target;

    // update path
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_hit;
    logic [CNT_W-1:0] w_cnt_cur;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_mis;
    logic             w_squash;

    assign w_f_idx    = f_pc[IDX_W-1:0];
    assign w_f_tag    = f_pc[PC_W-1:IDX_W];
    assign w_f_hit    = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign w_f_taken  = w_f_hit && r_cnt[w_f_idx][CNT_W-1];
    assign w_f_target = w_f_taken ? r_btb[w_f_idx] : (f_pc + C_PC_ONE);

    assign w_u_idx    = u_pc[IDX_W-1:0];
    assign w_u_tag    = u_pc[PC_W-1:IDX_W];
    assign w_u_hit    = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    assign w_cnt_cur  = r_cnt[w_u_idx];

    assign w_mis      = (u_taken != u_pred_taken) ||
                        (u_taken && (u_target != u_pred_target));
    assign w_squash   = u_valid && w_mis;

    // A taken branch that misses claims the entry and starts at weak-taken;
    // a not-taken branch that misses leaves the entry untouched.
    always_comb begin
        w_cnt_next = w_cnt_cur;
        if (u_taken) begin
            if (!w_u_hit) begin
                w_cnt_next = C_CNT_WEAK_T;
            end else if (w_cnt_cur != C_CNT_MAX) begin
                w_cnt_next = w_cnt_cur + C_CNT_ONE;
            end
        end else if (w_u_hit && (w_cnt_cur != C_CNT_MIN)) begin
            w_cnt_next = w_cnt_cur - C_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_btb[i]   <= '0;
                r_cnt[i]   <= C_CNT_WEAK_NT;
            end
        end else if (u_valid) begin
            r_cnt[w_u_idx] <= w_cnt_next;
            if (u_taken) begin
                r_valid[w_u_idx] <= 1'b1;
                r_tag[w_u_idx]   <= w_u_tag;
                r_btb[w_u_idx]   <= u_target;
            end
        end
    end

    // Squash wins over stall so the front end never consumes a stale prediction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_valid  <= 1'b0;
            r_p_taken  <= 1'b0;
            r_p_target <= '0;
        end else begin
            if (w_squash) begin
                r_p_valid <= 1'b0;
            end else if (!f_stall) begin
                r_p_valid <= f_valid;
            end
            if (!f_stall && f_valid) begin
                r_p_taken  <= w_f_taken;
                r_p_target <= w_f_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mispredict  <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_mispredict <= w_squash;
            if (u_valid) begin
                r_redirect_pc <= u_taken ? u_target : (u_pc + C_PC_ONE);
            end
        end
    end

    assign p_valid     = r_p_valid;
    assign p_taken     = r_p_taken;
    assign p_target    = r_p_target;
    assign mispredict  = r_mispredict;
    assign redirect_pc = r_redirect_pc;

endmodule
`default_nettype wire

// File: tb/tb_branch_pred_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_pred_unit
//  Description : Directed plus random stimulus against a table-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_pred_unit;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_valid, f_stall, u_valid, u_taken, u_pred_taken;
    logic [15:0] f_pc, u_pc, u_target, u_pred_target;
    logic        p_valid, p_taken, mispredict;
    logic [15:0] p_target, redirect_pc;

    always #5 clk = ~clk;

    branch_pred_unit #(.PC_W(16), .IDX_W(6), .CNT_W(2), .TAG_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_valid(f_valid), .f_pc(f_pc), .f_stall(f_stall),
        .p_valid(p_valid), .p_taken(p_taken), .p_target(p_target),
        .u_valid(u_valid), .u_pc(u_pc), .u_taken(u_taken), .u_target(u_target),
        .u_pred_taken(u_pred_taken), .u_pred_target(u_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model: per-entry state as plain integers
    bit   m_valid [DEPTH];
    int   m_tag   [DEPTH];
    int   m_tgt   [DEPTH];
    int   m_cnt   [DEPTH];
    logic        exp_pv, exp_pt, exp_mis;
    logic [15:0] exp_ptgt, exp_redir;

    logic [15:0] rfp, rup, rutg, rptg;
    logic        rut, rpt;
    int          ri;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
        end
        exp_pv = 1'b0; exp_pt = 1'b0; exp_ptgt = '0; exp_mis = 1'b0; exp_redir = '0;
    endtask

    function automatic bit model_hit(input logic [15:0] pc);
        return m_valid[int'(pc) % DEPTH] && (m_tag[int'(pc) % DEPTH] == int'(pc) / DEPTH);
    endfunction

    // Expected outputs after the coming edge, then the table training.
    task automatic model_edge();
        int fi, ui;
        bit fhit, uhit, mis;
        fi   = int'(f_pc) % DEPTH;
        ui   = int'(u_pc) % DEPTH;
        fhit = model_hit(f_pc);
        uhit = model_hit(u_pc);
        mis  = (u_taken != u_pred_taken) || (u_taken && (u_target != u_pred_target));
        if (!f_stall && f_valid) begin
            exp_pt   = fhit && (m_cnt[fi] >= 2);
            exp_ptgt = exp_pt ? 16'(m_tgt[fi]) : 16'(int'(f_pc) + 1);
        end
        if (u_valid && mis)  exp_pv = 1'b0;
        else if (!f_stall)   exp_pv = f_valid;
        exp_mis = u_valid && mis;
        if (u_valid) exp_redir = u_taken ? u_target : 16'(int'(u_pc) + 1);
        if (u_valid) begin
            if (u_taken) begin
                m_cnt[ui]   = uhit ? ((m_cnt[ui] == 3) ? 3 : m_cnt[ui] + 1) : 2;
                m_valid[ui] = 1'b1;
                m_tag[ui]   = int'(u_pc) / DEPTH;
                m_tgt[ui]   = int'(u_target);
            end else if (uhit && m_cnt[ui] > 0) begin
                m_cnt[ui] = m_cnt[ui] - 1;
            end
        end
    endtask

    task automatic check_all();
        chk1("p_valid", p_valid, exp_pv);
        if (exp_pv) begin
            chk1("p_taken", p_taken, exp_pt);
            chk16("p_target", p_target, exp_ptgt);
        end
        chk1("mispredict", mispredict, exp_mis);
        chk16("redirect_pc", redirect_pc, exp_redir);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_f(input logic v, input logic [15:0] pc, input logic st);
        f_valid = v; f_pc = pc; f_stall = st;
    endtask

    task automatic set_u(input logic v, input logic [15:0] pc, input logic t,
                         input logic [15:0] tgt, input logic pt, input logic [15:0] ptgt);
        u_valid = v; u_pc = pc; u_taken = t; u_target = tgt;
        u_pred_taken = pt; u_pred_target = ptgt;
    endtask

    initial begin
        rst_n = 1'b0;
        set_f(1'b0, 16'h0000, 1'b0);
        set_u(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        model_reset();
        #1;
        check_all();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // first lookup on an empty table, plus PC wrap
        set_f(1'b1, 16'h0040, 1'b0); tick();
        chk16("t1_target", p_target, 16'h0041);
        set_f(1'b1, 16'hFFFF, 1'b0); tick();
        chk16("wrap_target", p_target, 16'h0000);

        // first taken resolution mispredicts and trains the entry
        set_f(1'b0, 16'h0000, 1'b0);
        set_u(1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0041); tick();
        chk16("t2_redirect", redirect_pc, 16'h0100);
        set_u(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        set_f(1'b1, 16'h0040, 1'b0); tick();
        chk16("t2_target", p_target, 16'h0100);

        // saturation then decay
        set_f(1'b0, 16'h0000, 1'b0);
        repeat (3) begin
            set_u(1'b1, 16'h0040, 1'b1, 16'h0100, 1'b1, 16'h0100); tick();
        end
        set_u(1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0100); tick();
        chk16("t3_redirect", redirect_pc, 16'h0041);
        set_u(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        set_f(1'b1, 16'h0040, 1'b0); tick();
        chk1("t3_still_taken", p_taken, 1'b1);
        set_f(1'b0, 16'h0000, 1'b0);
        set_u(1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0100); tick();
        set_u(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        set_f(1'b1, 16'h0040, 1'b0); tick();
        chk1("t3_not_taken", p_taken, 1'b0);

        // aliasing at index 0
        set_f(1'b0, 16'h0000, 1'b0);
        set_u(1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0041); tick();
        set_u(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        set_f(1'b1, 16'h0080, 1'b0); tick();
        chk1("t4_alias_taken", p_taken, 1'b0);
        set_f(1'b0, 16'h0000, 1'b0);
        set_u(1'b1, 16'h0080, 1'b1, 16'h0200, 1'b0, 16'h0081); tick();
        set_u(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        set_f(1'b1, 16'h0080, 1'b0); tick();
        chk16("t4_new_target", p_target, 16'h0200);
        set_f(1'b0, 16'h0000, 1'b0);
        set_u(1'b1, 16'h0080, 1'b0, 16'h0000, 1'b1, 16'h0200); tick();
        set_u(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        set_f(1'b1, 16'h0080, 1'b0); tick();
        chk1("t4_cnt_was_10", p_taken, 1'b0);

        // read-before-write, stall hold, squash during stall
        set_f(1'b1, 16'h0045, 1'b0);
        set_u(1'b1, 16'h0045, 1'b1, 16'h0300, 1'b1, 16'h0300); tick();
        chk1("t5_rbw_taken", p_taken, 1'b0);
        set_u(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000); tick();
        chk1("t5_next_taken", p_taken, 1'b1);
        set_f(1'b1, 16'h0123, 1'b1);
        repeat (2) tick();
        chk16("t5_stall_hold", p_target, 16'h0300);
        set_u(1'b1, 16'h0047, 1'b1, 16'h0400, 1'b0, 16'h0048); tick();
        chk1("t5_squash", p_valid, 1'b0);

        // asynchronous reset between edges
        set_u(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        set_f(1'b1, 16'h0045, 1'b0); tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk1("t6_rst_pv", p_valid, 1'b0);
        chk1("t6_rst_pt", p_taken, 1'b0);
        chk16("t6_rst_ptgt", p_target, 16'h0000);
        chk1("t6_rst_mis", mispredict, 1'b0);
        chk16("t6_rst_redir", redirect_pc, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        chk1("t6_untrained", p_taken, 1'b0);

        // random traffic over a small PC space to force hits and aliases
        for (int k = 0; k < 600; k++) begin
            rfp  = 16'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
            rup  = 16'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
            rut  = 1'($urandom_range(0, 1));
            rutg = 16'($urandom_range(1, 4) << 8);
            ri   = int'(rup) % DEPTH;
            if ($urandom_range(0, 1) == 1) begin
                rpt  = model_hit(rup) && (m_cnt[ri] >= 2);
                rptg = rpt ? 16'(m_tgt[ri]) : 16'(int'(rup) + 1);
            end else begin
                rpt  = 1'($urandom_range(0, 1));
                rptg = ($urandom_range(0, 1) == 1) ? rutg : 16'($urandom);
            end
            set_f($urandom_range(0, 3) != 0, rfp, $urandom_range(0, 4) == 0);
            set_u($urandom_range(0, 2) != 0, rup, rut, rutg, rpt, rptg);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
